axi_ar_issue_buffer: RTL and testbench
======================================

# axi_AR_issue_buffer

Read-address stage placed directly downstream of the AR allocator and upstream of a node master port. It registers the arbitrated AR channel in a 2-entry FIFO, which breaks the combinational valid/ready path of the arbitration tree. It also caps the number of in-flight read bursts toward the slave by counting AR issues against R-channel last beats. Payload is carried unmodified, including the extended ID whose MSBs hold the originating target-port index.

## Interface
- AXI_ADDRESS_W, 32, address width
- AXI_USER_W, 6, user width
- AXI_ID, 19, extended ID width (input ID plus port-index bits)
- MAX_OUTSTANDING, 8, maximum in-flight read bursts; legal range 1..255
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-counter width
- clk  in  1  clock; every register updates on the rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- arid_i / araddr_i / arlen_i / arsize_i / arburst_i / arlock_i / arcache_i / arprot_i / arregion_i / aruser_i / arqos_i  in  AXI_ID / AXI_ADDRESS_W / 8 / 3 / 2 / 1 / 4 / 3 / 4 / AXI_USER_W / 4  AR payload from the allocator
- arvalid_i  in  1  allocator request
- arready_o  out  1  buffer can accept
- arid_o … arqos_o  out  same widths as the inputs  registered AR payload to the master port
- arvalid_o  out  1  issue request
- arready_i  in  1  slave accepts
- rvalid_i, rready_i, rlast_i  in  1 each  monitored R-channel handshake; the block only observes these signals and does not drive them
- outstanding_o  out  CNT_W  current in-flight burst count
- err_o  out  1  sticky flag for underflow (an R last beat arriving with no burst outstanding)

## Operation
- FIFO: 2 entries, each holding all 11 payload fields. Bursts leave in the order they arrived. There is a write pointer, a read pointer (both 1 bit) and a fill count (0..2).
- Push = arvalid_i & arready_o. Pop = arvalid_o & arready_i.
- arready_o = (fill != 2) & ~rst. It depends only on fill, never on arready_i.
- Issue gate: arvalid_o = (fill != 0) & (outstanding < MAX_OUTSTANDING).
- Output payload = entry[rd_ptr]. It stays stable while arvalid_o=1 and arready_i=0.
- Once arvalid_o is asserted it does not drop before pop. This holds by construction: outstanding only increments on pop, and fill only decrements on pop.
- Counter: the increment condition is pop. The decrement condition is rvalid_i & rready_i & rlast_i. When both happen in the same cycle, the count is unchanged.
- Decrement while outstanding=0: the count stays at 0 and err_o is set. err_o is cleared only by rst.
- Push and pop in the same cycle with fill=1: fill stays 1, both pointers advance, and the new entry is written to the slot not being read.
- Push when fill=0: no bypass path exists, so the data reaches arvalid_o on the next cycle.

## Timing
- Reset values (asserted asynchronously, held while rst=1):
  - fill=0, both pointers=0
  - arvalid_o=0, arready_o=0
  - outstanding_o=0, err_o=0
  - payload outputs are don't-care; the FIFO storage is not reset.
- First edge after rst deasserts: arready_o=1.
- Latency: a push at edge N makes arvalid_o=1 after edge N, provided outstanding < MAX.
- Throughput: 1 AR per cycle sustained while arready_i=1 and the outstanding limit is not reached.
- outstanding_o reflects the pop at edge N from edge N onward, so arvalid_o deasserts in the cycle after the pop that reaches MAX.
- A decrement at edge N can release a gated arvalid_o in the cycle following edge N.
- rst asserted mid-burst: all in-flight state is discarded. The upstream allocator and downstream slave are reset by the same rst.

## Test plan
- Reset, then 3 back-to-back pushes with arready_i=1 and R idle -> arvalid_o first rises 1 cycle after the first push; arid_o sequence matches the input order; outstanding_o=3.
- arready_i=0, 3 pushes -> arready_o drops after the 2nd push; the 3rd is held upstream; payload on arid_o stays constant; fill=2.
- MAX_OUTSTANDING=2, 4 queued ARs, arready_i=1, R idle -> exactly 2 issued; arvalid_o=0 with fill=2; one rlast handshake -> 3rd AR issues on the next cycle.
- Pop and rlast handshake in the same cycle with outstanding=1 -> outstanding_o stays 1.
- rlast handshake with outstanding=0 -> outstanding_o=0, err_o=1 and held; an AR issued afterwards counts normally.
- Reset asserted with fill=2 and outstanding=5 -> arvalid_o=0, arready_o=0 and outstanding_o=0 without waiting for a clock edge; arready_o=1 at the first edge after release.

Source files
------------

// File: rtl/axi_ar_issue_buffer.sv
// AR issue buffer: a 2-entry FIFO that registers the arbitrated read-address
// channel, plus an in-flight read-burst limiter driven by AR issues and R
// last beats. The payload passes through unmodified.
module axi_ar_issue_buffer #(
  parameter int AXI_ADDRESS_W   = 32,
  parameter int AXI_USER_W      = 6,
  parameter int AXI_ID          = 19,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,

  // AR channel from the allocator
  input  logic [AXI_ID-1:0]        arid_i,
  input  logic [AXI_ADDRESS_W-1:0] araddr_i,
  input  logic [7:0]               arlen_i,
  input  logic [2:0]               arsize_i,
  input  logic [1:0]               arburst_i,
  input  logic                     arlock_i,
  input  logic [3:0]               arcache_i,
  input  logic [2:0]               arprot_i,
  input  logic [3:0]               arregion_i,
  input  logic [AXI_USER_W-1:0]    aruser_i,
  input  logic [3:0]               arqos_i,
  input  logic                     arvalid_i,
  output logic                     arready_o,

  // AR channel toward the master port
  output logic [AXI_ID-1:0]        arid_o,
  output logic [AXI_ADDRESS_W-1:0] araddr_o,
  output logic [7:0]               arlen_o,
  output logic [2:0]               arsize_o,
  output logic [1:0]               arburst_o,
  output logic                     arlock_o,
  output logic [3:0]               arcache_o,
  output logic [2:0]               arprot_o,
  output logic [3:0]               arregion_o,
  output logic [AXI_USER_W-1:0]    aruser_o,
  output logic [3:0]               arqos_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,

  // R channel, observed only
  input  logic                     rvalid_i,
  input  logic                     rready_i,
  input  logic                     rlast_i,

  output logic [CNT_W-1:0]         outstanding_o,
  output logic                     err_o
);

  // One FIFO entry carries every AR field side by side.
  localparam int PAYLOAD_W = AXI_ID + AXI_ADDRESS_W + 8 + 3 + 2 + 1 + 4 + 3 + 4
                             + AXI_USER_W + 4;
  localparam int DEPTH = 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [1:0] FILL_EMPTY = 2'd0;
  localparam logic [1:0] FILL_FULL  = 2'd2;

  logic [PAYLOAD_W-1:0] payload_in;
  logic [PAYLOAD_W-1:0] payload_out;
  logic [PAYLOAD_W-1:0] slot_data [DEPTH];

  logic             wr_ptr_reg;
  logic             wr_ptr_next;
  logic             rd_ptr_reg;
  logic             rd_ptr_next;
  logic [1:0]       fill_reg;
  logic [1:0]       fill_next;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] outstanding_next;
  logic             err_reg;
  logic             err_next;

  logic push;
  logic pop;
  logic r_last_hs;
  logic issue_allowed;

  // Flatten the incoming AR fields into a single storage word.
  always_comb begin
    payload_in = {arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arlock_i,
                  arcache_i, arprot_i, arregion_i, aruser_i, arqos_i};
  end

  // Acceptance depends only on occupancy so the upstream arbitration tree
  // never sees a combinational path from the slave's arready.
  assign arready_o     = (fill_reg != FILL_FULL) & ~rst;
  // Issue is held back while the read-burst budget is exhausted; both terms
  // can only change against arvalid_o through a pop, so a raised arvalid_o
  // stays up until accepted.
  assign issue_allowed = (outstanding_reg < MAX_CNT);
  assign arvalid_o     = (fill_reg != FILL_EMPTY) & issue_allowed;

  assign push      = arvalid_i & arready_o;
  assign pop       = arvalid_o & arready_i;
  assign r_last_hs = rvalid_i & rready_i & rlast_i;

  // Storage slots: plain registers with no reset; a slot is written only when
  // the write pointer selects it, so with fill=1 a simultaneous push lands in
  // the slot that is not being read.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PAYLOAD_W-1:0] slot_reg;

      // Capture the incoming payload into this slot on a targeted push.
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          slot_reg <= payload_in;
        end
      end

      assign slot_data[gi] = slot_reg;
    end
  endgenerate

  // Head of the FIFO drives the master port directly; it is register-held,
  // so it stays stable while the slave back-pressures.
  assign payload_out = slot_data[rd_ptr_reg];

  // Unpack the head entry onto the outgoing AR fields.
  always_comb begin
    {arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o,
     arcache_o, arprot_o, arregion_o, aruser_o, arqos_o} = payload_out;
  end

  // Pointer and occupancy bookkeeping for push, pop, or both together.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    fill_next   = fill_reg;
    if (push) begin
      wr_ptr_next = ~wr_ptr_reg;
    end
    if (pop) begin
      rd_ptr_next = ~rd_ptr_reg;
    end
    case ({push, pop})
      2'b10:   fill_next = fill_reg + 2'd1;
      2'b01:   fill_next = fill_reg - 2'd1;
      default: fill_next = fill_reg;
    endcase
  end

  // In-flight burst counter: +1 per AR issued, -1 per R last beat; the two
  // cancel out in the same cycle. A last beat with nothing in flight is an
  // underflow: the count saturates at zero and the sticky error is raised.
  always_comb begin
    outstanding_next = outstanding_reg;
    err_next         = err_reg;
    if (pop && !r_last_hs) begin
      outstanding_next = outstanding_reg + CNT_W'(1);
    end else if (r_last_hs && !pop) begin
      if (outstanding_reg == '0) begin
        err_next = 1'b1;
      end else begin
        outstanding_next = outstanding_reg - CNT_W'(1);
      end
    end
  end

  // Control state register; reset discards every in-flight record at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      fill_reg        <= FILL_EMPTY;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      fill_reg        <= fill_next;
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign outstanding_o = outstanding_reg;
  assign err_o         = err_reg;

endmodule

// File: tb/tb_axi_ar_issue_buffer.sv
// Bench for axi_ar_issue_buffer: vector table, hand-written corner sequences,
// and randomized traffic checked against a queue/counter reference model.
module tb_axi_ar_issue_buffer;

  localparam int PW = 86;  // 19+32+8+3+2+1+4+3+4+6+4

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PW-1:0] pay_in;

  // instance a: MAX_OUTSTANDING = 8
  logic          a_arvalid, a_arready, a_rvalid, a_rready, a_rlast;
  logic          a_ready_out, a_valid_out, a_err;
  logic [PW-1:0] a_pay;
  logic [3:0]    a_out;

  // instance b: MAX_OUTSTANDING = 2
  logic          b_arvalid, b_arready, b_rvalid, b_rready, b_rlast;
  logic          b_ready_out, b_valid_out, b_err;
  logic [PW-1:0] b_pay;
  logic [1:0]    b_out;

  axi_ar_issue_buffer #(.MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst(rst),
    .arid_i(pay_in[85:67]), .araddr_i(pay_in[66:35]), .arlen_i(pay_in[34:27]),
    .arsize_i(pay_in[26:24]), .arburst_i(pay_in[23:22]), .arlock_i(pay_in[21]),
    .arcache_i(pay_in[20:17]), .arprot_i(pay_in[16:14]), .arregion_i(pay_in[13:10]),
    .aruser_i(pay_in[9:4]), .arqos_i(pay_in[3:0]),
    .arvalid_i(a_arvalid), .arready_o(a_ready_out),
    .arid_o(a_pay[85:67]), .araddr_o(a_pay[66:35]), .arlen_o(a_pay[34:27]),
    .arsize_o(a_pay[26:24]), .arburst_o(a_pay[23:22]), .arlock_o(a_pay[21]),
    .arcache_o(a_pay[20:17]), .arprot_o(a_pay[16:14]), .arregion_o(a_pay[13:10]),
    .aruser_o(a_pay[9:4]), .arqos_o(a_pay[3:0]),
    .arvalid_o(a_valid_out), .arready_i(a_arready),
    .rvalid_i(a_rvalid), .rready_i(a_rready), .rlast_i(a_rlast),
    .outstanding_o(a_out), .err_o(a_err)
  );

  axi_ar_issue_buffer #(.MAX_OUTSTANDING(2)) dut_max2 (
    .clk(clk), .rst(rst),
    .arid_i(pay_in[85:67]), .araddr_i(pay_in[66:35]), .arlen_i(pay_in[34:27]),
    .arsize_i(pay_in[26:24]), .arburst_i(pay_in[23:22]), .arlock_i(pay_in[21]),
    .arcache_i(pay_in[20:17]), .arprot_i(pay_in[16:14]), .arregion_i(pay_in[13:10]),
    .aruser_i(pay_in[9:4]), .arqos_i(pay_in[3:0]),
    .arvalid_i(b_arvalid), .arready_o(b_ready_out),
    .arid_o(b_pay[85:67]), .araddr_o(b_pay[66:35]), .arlen_o(b_pay[34:27]),
    .arsize_o(b_pay[26:24]), .arburst_o(b_pay[23:22]), .arlock_o(b_pay[21]),
    .arcache_o(b_pay[20:17]), .arprot_o(b_pay[16:14]), .arregion_o(b_pay[13:10]),
    .aruser_o(b_pay[9:4]), .arqos_o(b_pay[3:0]),
    .arvalid_o(b_valid_out), .arready_i(b_arready),
    .rvalid_i(b_rvalid), .rready_i(b_rready), .rlast_i(b_rlast),
    .outstanding_o(b_out), .err_o(b_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // every field of a table payload is derived from its ID
  function automatic logic [PW-1:0] mkpay(input logic [18:0] id);
    return {id, id, id, id, 10'h2A5};
  endfunction

  typedef struct {
    logic        av;
    logic        rdy;
    logic        rl;
    logic [18:0] id;
    logic        e_ardy;
    logic        e_avld;
    logic [18:0] e_id;
    int          e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic av, input logic rdy, input logic rl,
                               input logic [18:0] id, input logic e_ardy,
                               input logic e_avld, input logic [18:0] e_id,
                               input int e_out, input logic e_err);
    vec_t v;
    v.av = av; v.rdy = rdy; v.rl = rl; v.id = id;
    v.e_ardy = e_ardy; v.e_avld = e_avld; v.e_id = e_id;
    v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  task automatic idle_all();
    a_arvalid = 0; a_arready = 0; a_rvalid = 0; a_rready = 0; a_rlast = 0;
    b_arvalid = 0; b_arready = 0; b_rvalid = 0; b_rready = 0; b_rlast = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] mq[$];
    int            mcnt;
    logic          merr;
    logic [95:0]   rnd;
    logic [18:0]   ids[4];
    int            k, pops, acc, iss;
    logic          p_push, p_pop, p_dec;

    idle_all();
    pay_in = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_arready", a_ready_out, 0);
    chk("reset_arvalid", a_valid_out, 0);
    chk("reset_outstanding", a_out, 0);
    chk("reset_err", a_err, 0);
    chk("reset_arready_max2", b_ready_out, 0);
    rst = 1'b0;
    #1;
    chk("release_arready", a_ready_out, 1);

    // ---------------- vector table ----------------
    // back-to-back pushes, slave ready
    tbl.push_back(row(1, 1, 0, 19'h11, 1, 0, 0,      0, 0));
    tbl.push_back(row(1, 1, 0, 19'h22, 1, 1, 19'h11, 0, 0));
    tbl.push_back(row(1, 1, 0, 19'h33, 1, 1, 19'h22, 1, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 1, 19'h33, 2, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 0, 0,      3, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      3, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      2, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      1, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 0, 0,      0, 0));
    // slave stalled: FIFO fills, third request held upstream
    tbl.push_back(row(1, 0, 0, 19'h44, 1, 0, 0,      0, 0));
    tbl.push_back(row(1, 0, 0, 19'h55, 1, 1, 19'h44, 0, 0));
    tbl.push_back(row(1, 0, 0, 19'h66, 0, 1, 19'h44, 0, 0));
    tbl.push_back(row(1, 0, 0, 19'h66, 0, 1, 19'h44, 0, 0));
    tbl.push_back(row(1, 1, 0, 19'h66, 0, 1, 19'h44, 0, 0));
    tbl.push_back(row(1, 1, 0, 19'h66, 1, 1, 19'h55, 1, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 1, 19'h66, 2, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      3, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      2, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      1, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 0, 0,      0, 0));
    // pop and R last in the same cycle with one burst in flight
    tbl.push_back(row(1, 1, 0, 19'h77, 1, 0, 0,      0, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 1, 19'h77, 0, 0));
    tbl.push_back(row(1, 1, 0, 19'h08, 1, 0, 0,      1, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 1, 19'h08, 1, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 0, 0,      1, 0));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      1, 0));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 0, 0,      0, 0));
    // underflow: sticky error, later issue still counted
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      0, 0));
    tbl.push_back(row(1, 1, 0, 19'h19, 1, 0, 0,      0, 1));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 1, 19'h19, 0, 1));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 0, 0,      1, 1));
    tbl.push_back(row(0, 1, 1, 19'h0,  1, 0, 0,      1, 1));
    tbl.push_back(row(0, 1, 0, 19'h0,  1, 0, 0,      0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      a_arvalid = tbl[i].av;
      a_arready = tbl[i].rdy;
      pay_in    = mkpay(tbl[i].id);
      a_rvalid  = tbl[i].rl;
      a_rready  = tbl[i].rl;
      a_rlast   = tbl[i].rl;
      #1;
      $display("vec %0d: av=%0b rdy=%0b rl=%0b id=%0h -> ardy=%0b avld=%0b arid=%0h out=%0d err=%0b",
               i, tbl[i].av, tbl[i].rdy, tbl[i].rl, tbl[i].id,
               a_ready_out, a_valid_out, a_pay[85:67], a_out, a_err);
      chk($sformatf("vec%0d_arready", i), a_ready_out, tbl[i].e_ardy);
      chk($sformatf("vec%0d_arvalid", i), a_valid_out, tbl[i].e_avld);
      chk($sformatf("vec%0d_outstanding", i), a_out, tbl[i].e_out);
      chk($sformatf("vec%0d_err", i), a_err, tbl[i].e_err);
      if (tbl[i].e_avld) chk($sformatf("vec%0d_payload", i), a_pay, mkpay(tbl[i].e_id));
      @(posedge clk);
      @(negedge clk);
    end
    idle_all();

    // ---------------- MAX_OUTSTANDING = 2 gating ----------------
    ids[0] = 19'h101; ids[1] = 19'h102; ids[2] = 19'h103; ids[3] = 19'h104;
    k = 0; pops = 0;
    b_arready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      b_arvalid = (k < 4);
      pay_in    = mkpay(ids[k < 4 ? k : 3]);
      #1;
      p_push = b_arvalid & b_ready_out;
      p_pop  = b_valid_out & b_arready;
      $display("max2 cycle %0d: push=%0b pop=%0b out=%0d", c, p_push, p_pop, b_out);
      @(posedge clk);
      if (p_push) k++;
      if (p_pop) pops++;
      @(negedge clk);
    end
    b_arvalid = 1'b0;
    #1;
    chk("max2_issued", pops, 2);
    chk("max2_gated_arvalid", b_valid_out, 0);
    chk("max2_full_arready", b_ready_out, 0);
    chk("max2_outstanding", b_out, 2);
    b_rvalid = 1; b_rready = 1; b_rlast = 1;
    @(posedge clk);
    @(negedge clk);
    b_rvalid = 0; b_rready = 0; b_rlast = 0;
    #1;
    $display("max2 after rlast: avld=%0b arid=%0h out=%0d", b_valid_out, b_pay[85:67], b_out);
    chk("max2_release_arvalid", b_valid_out, 1);
    chk("max2_release_arid", b_pay[85:67], ids[2]);
    chk("max2_release_outstanding", b_out, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("max2_regate_arvalid", b_valid_out, 0);
    chk("max2_regate_outstanding", b_out, 2);
    chk("max2_regate_arready", b_ready_out, 1);
    idle_all();

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    mq.delete();
    mcnt = 0;
    merr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      a_arvalid = ($urandom_range(0, 3) != 0);
      a_arready = ($urandom_range(0, 2) != 0);
      rnd = {$urandom, $urandom, $urandom};
      pay_in = rnd[PW-1:0];
      p_push = a_arvalid && (mq.size() < 2);
      p_pop  = a_arready && (mq.size() > 0) && (mcnt < 8);
      p_dec  = ($urandom_range(0, 2) == 0);
      if (mcnt == 0 && p_pop) p_dec = 1'b0;
      a_rvalid = p_dec | ($urandom_range(0, 1) == 1);
      a_rready = p_dec | ~a_rvalid;
      a_rlast  = p_dec | ($urandom_range(0, 1) == 1 && !(a_rvalid && a_rready));
      p_dec    = a_rvalid & a_rready & a_rlast;
      #1;
      $display("rnd %0d: push=%0b pop=%0b rlast_hs=%0b fill=%0d out=%0d err=%0b",
               c, p_push, p_pop, p_dec, mq.size(), a_out, a_err);
      chk($sformatf("rnd%0d_arready", c), a_ready_out, (mq.size() < 2));
      chk($sformatf("rnd%0d_arvalid", c), a_valid_out, (mq.size() > 0) && (mcnt < 8));
      chk($sformatf("rnd%0d_outstanding", c), a_out, mcnt);
      chk($sformatf("rnd%0d_err", c), a_err, merr);
      if (mq.size() > 0) chk($sformatf("rnd%0d_payload", c), a_pay, mq[0]);
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back(pay_in);
      if (p_pop && !p_dec) mcnt++;
      else if (p_dec && !p_pop) begin
        if (mcnt == 0) merr = 1'b1;
        else mcnt--;
      end
      @(posedge clk);
      @(negedge clk);
    end
    idle_all();

    // ---------------- asynchronous reset with fill=2, outstanding=5 ----------------
    do_reset();
    acc = 0; iss = 0;
    for (int c = 0; c < 20 && !(acc == 7 && iss == 5); c++) begin
      a_arvalid = (acc < 7);
      a_arready = (iss < 5);
      pay_in    = mkpay(19'(19'h200 + acc));
      #1;
      p_push = a_arvalid & a_ready_out;
      p_pop  = a_valid_out & a_arready;
      @(posedge clk);
      if (p_push) acc++;
      if (p_pop) iss++;
      @(negedge clk);
    end
    a_arvalid = 0; a_arready = 0;
    #1;
    $display("pre-reset: accepted=%0d issued=%0d ardy=%0b avld=%0b out=%0d",
             acc, iss, a_ready_out, a_valid_out, a_out);
    chk("prereset_issued", iss, 5);
    chk("prereset_full_arready", a_ready_out, 0);
    chk("prereset_arvalid", a_valid_out, 1);
    chk("prereset_outstanding", a_out, 5);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_arvalid", a_valid_out, 0);
    chk("async_reset_arready", a_ready_out, 0);
    chk("async_reset_outstanding", a_out, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_release_arready", a_ready_out, 1);
    chk("post_release_arvalid", a_valid_out, 0);
    chk("post_release_err", a_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
